// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and key codes for the paddle serial input path.
// The BREAK state exists only when UART_RX_FRAME_ERR_EN is defined.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  localparam logic [UART_DATA_BITS-1:0] KEY_UP  = 8'h26;
  localparam logic [UART_DATA_BITS-1:0] KEY_DWN = 8'h28;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
`ifdef UART_RX_FRAME_ERR_EN
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
`else
    ST_STOP  = 3'd3
`endif
  } rx_state_t;

endpackage

// File: rtl/uart_byte_rx_if.sv
// rtl/uart_byte_rx_if.sv - received-byte bus from the UART front end to the paddle controllers.
// frame_err is carried only when UART_RX_FRAME_ERR_EN is defined.
interface uart_byte_rx_if;
  import uart_pkg::*;

  logic                      data_valid;
  logic [UART_DATA_BITS-1:0] data_byte_op;
`ifdef UART_RX_FRAME_ERR_EN
  logic                      frame_err;

  modport master (output data_valid, output data_byte_op, output frame_err);
  modport slave  (input  data_valid, input  data_byte_op, input  frame_err);
`else
  modport master (output data_valid, output data_byte_op);
  modport slave  (input  data_valid, input  data_byte_op);
`endif
endinterface

// File: rtl/uart_byte_rx_sync2.sv
// rtl/uart_byte_rx_sync2.sv - two-flop synchronizer for the idle-high serial line.
// Both stages reset to 1 so reset never looks like a start bit.
module rx_sync2 (
  input  logic clk_in,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_byte_rx.sv
// rtl/uart_byte_rx.sv - 8N1 mid-bit-sampling UART byte receiver for the paddle input path.
// Stop-bit checking and the BREAK state are enabled by UART_RX_FRAME_ERR_EN.
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic           clk_in,
  input  logic           rst,
  input  logic           serial_data_in,
  uart_byte_rx_if.master rx_bus
);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]       IDX_LAST  = 3'(UART_DATA_BITS - 1);

  logic rx_s;

  rx_state_t                 state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [2:0]                idx_q, idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [UART_DATA_BITS-1:0] byte_q, byte_d;
  logic                      valid_q, valid_d;
`ifdef UART_RX_FRAME_ERR_EN
  logic                      ferr_q, ferr_d;
`endif

  rx_sync2 u_sync (
    .clk_in (clk_in),
    .rst    (rst),
    .d      (serial_data_in),
    .q      (rx_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    valid_d = 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
    ferr_d  = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rx_s) state_d = ST_START;
      end
      ST_START: begin
        // Re-check the line at mid start bit to reject short glitches.
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          state_d = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          idx_d          = idx_q + 3'd1;
          if (idx_q == IDX_LAST) state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
`ifdef UART_RX_FRAME_ERR_EN
          if (rx_s) begin
            byte_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ferr_d  = 1'b1;
            state_d = ST_BREAK;
          end
`else
          byte_d  = shift_q;
          valid_d = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef UART_RX_FRAME_ERR_EN
      ST_BREAK: begin
        // A held-low line reports once, then waits for idle before rearming.
        cnt_d = '0;
        if (rx_s) state_d = ST_IDLE;
      end
`endif
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      byte_q  <= '0;
      valid_q <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
      ferr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
`ifdef UART_RX_FRAME_ERR_EN
      ferr_q  <= ferr_d;
`endif
    end
  end

  assign rx_bus.data_valid   = valid_q;
  assign rx_bus.data_byte_op = byte_q;
`ifdef UART_RX_FRAME_ERR_EN
  assign rx_bus.frame_err    = ferr_q;
`endif

endmodule

// File: tb/tb_uart_byte_rx.sv
// tb/tb_uart_byte_rx.sv - scoreboard bench for uart_byte_rx at 16 clocks per bit.
// Frame-error scenarios follow UART_RX_FRAME_ERR_EN.
module tb_uart_byte_rx;
  import uart_pkg::*;

  localparam int N   = 16;
  localparam int H   = N / 2;
  localparam int LAT = 2 + 1 + H + 9 * N;

  logic clk_in = 1'b0;
  logic rst;
  logic serial_data_in;

  uart_byte_rx_if rx_if ();

  uart_byte_rx #(.CLKS_PER_BIT(N)) dut (
    .clk_in         (clk_in),
    .rst            (rst),
    .serial_data_in (serial_data_in),
    .rx_bus         (rx_if.master)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int dv_double = 0;
  int byte_glitch = 0;
  logic       prev_dv = 1'b0;
  logic [7:0] prev_byte = 8'h00;

  logic [7:0] exp_q[$];
  logic [7:0] obs_byte[$];
  int         obs_cyc[$];
  int         err_cyc[$];

  // One clock; outputs sampled at the falling edge and logged for the tests.
  task automatic tick();
    @(posedge clk_in);
    cyc++;
    @(negedge clk_in);
    if (rx_if.data_valid === 1'b1) begin
      obs_byte.push_back(rx_if.data_byte_op);
      obs_cyc.push_back(cyc);
      if (prev_dv) dv_double++;
    end else if (rst === 1'b0 && rx_if.data_byte_op !== prev_byte) begin
      byte_glitch++;
    end
`ifdef UART_RX_FRAME_ERR_EN
    if (rx_if.frame_err === 1'b1) err_cyc.push_back(cyc);
`endif
    prev_dv   = rx_if.data_valid;
    prev_byte = rx_if.data_byte_op;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    serial_data_in = 1'b0;
    repeat (N) tick();
    for (int i = 0; i < 8; i++) begin
      serial_data_in = b[i];
      repeat (N) tick();
    end
    serial_data_in = stop_bit;
    repeat (N) tick();
    serial_data_in = 1'b1;
  endtask

  task automatic clear_logs();
    exp_q.delete();
    obs_byte.delete();
    obs_cyc.delete();
    err_cyc.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    serial_data_in = 1'b1;
    repeat (3) tick();
    checks++;
    if (rx_if.data_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid got %b want 0", rx_if.data_valid);
    end
    checks++;
    if (rx_if.data_byte_op !== 8'h00) begin
      errors++;
      $display("FAIL reset_byte got %h want 00", rx_if.data_byte_op);
    end
`ifdef UART_RX_FRAME_ERR_EN
    checks++;
    if (rx_if.frame_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_ferr got %b want 0", rx_if.frame_err);
    end
`endif
    rst = 1'b0;
    repeat (4 * N) tick();
    checks++;
    if (obs_byte.size() !== 0) begin
      errors++;
      $display("FAIL idle_no_strobe got %0d strobes want 0", obs_byte.size());
    end
    clear_logs();
  endtask

  task automatic test_false_start();
    serial_data_in = 1'b0;
    repeat (4) tick();
    serial_data_in = 1'b1;
    repeat (3 * N) tick();
    checks++;
    if (obs_byte.size() !== 0) begin
      errors++;
      $display("FAIL false_start_strobes got %0d want 0", obs_byte.size());
    end
    checks++;
    if (rx_if.data_byte_op !== 8'h00) begin
      errors++;
      $display("FAIL false_start_byte got %h want 00", rx_if.data_byte_op);
    end
    clear_logs();
  endtask

  task automatic test_byte_up();
    int c0;
    logic [7:0] e;
    c0 = cyc;
    exp_q.push_back(KEY_UP);
    send_frame(KEY_UP, 1'b1);
    repeat (2 * N) tick();
    checks++;
    if (obs_byte.size() !== 1) begin
      errors++;
      $display("FAIL up_count got %0d want 1", obs_byte.size());
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (obs_byte[0] !== e) begin
        errors++;
        $display("FAIL up_value got %h want %h", obs_byte[0], e);
      end
      checks++;
      if (obs_cyc[0] !== c0 + LAT) begin
        errors++;
        $display("FAIL up_latency got %0d want %0d", obs_cyc[0] - c0, LAT);
      end
    end
    checks++;
    if (rx_if.data_byte_op !== KEY_UP) begin
      errors++;
      $display("FAIL up_hold got %h want %h", rx_if.data_byte_op, KEY_UP);
    end
    clear_logs();
  endtask

  task automatic test_back_to_back();
    exp_q.push_back(KEY_DWN);
    send_frame(KEY_DWN, 1'b1);
    exp_q.push_back(KEY_UP);
    send_frame(KEY_UP, 1'b1);
    repeat (2 * N) tick();
    checks++;
    if (obs_byte.size() !== 2) begin
      errors++;
      $display("FAIL b2b_count got %0d want 2", obs_byte.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        logic [7:0] e;
        e = exp_q.pop_front();
        checks++;
        if (obs_byte[i] !== e) begin
          errors++;
          $display("FAIL b2b_value%0d got %h want %h", i, obs_byte[i], e);
        end
      end
      checks++;
      if (obs_cyc[1] - obs_cyc[0] !== 10 * N) begin
        errors++;
        $display("FAIL b2b_spacing got %0d want %0d", obs_cyc[1] - obs_cyc[0], 10 * N);
      end
    end
    clear_logs();
  endtask

  task automatic test_bad_stop();
`ifndef UART_RX_FRAME_ERR_EN
    exp_q.push_back(8'h55);
`endif
    send_frame(8'h55, 1'b0);
    repeat (3 * N) tick();
    checks++;
    if (obs_byte.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL bad_stop_count got %0d want %0d", obs_byte.size(), exp_q.size());
    end
`ifdef UART_RX_FRAME_ERR_EN
    checks++;
    if (err_cyc.size() !== 1) begin
      errors++;
      $display("FAIL bad_stop_ferr got %0d pulses want 1", err_cyc.size());
    end
    checks++;
    if (rx_if.data_byte_op !== KEY_UP) begin
      errors++;
      $display("FAIL bad_stop_hold got %h want %h", rx_if.data_byte_op, KEY_UP);
    end
`else
    checks++;
    if (obs_byte.size() != 0 && obs_byte[0] !== 8'h55) begin
      errors++;
      $display("FAIL bad_stop_value got %h want 55", obs_byte[0]);
    end
`endif
    clear_logs();
  endtask

  task automatic test_break();
`ifdef UART_RX_FRAME_ERR_EN
    serial_data_in = 1'b0;
    repeat (400) tick();
    serial_data_in = 1'b1;
`else
    exp_q.push_back(8'h00);
    send_frame(8'h00, 1'b0);
`endif
    repeat (3 * N) tick();
    exp_q.push_back(KEY_DWN);
    send_frame(KEY_DWN, 1'b1);
    repeat (2 * N) tick();
`ifdef UART_RX_FRAME_ERR_EN
    checks++;
    if (err_cyc.size() !== 1) begin
      errors++;
      $display("FAIL break_ferr got %0d pulses want 1", err_cyc.size());
    end
`endif
    checks++;
    if (obs_byte.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL break_count got %0d want %0d", obs_byte.size(), exp_q.size());
    end else begin
      for (int i = 0; i < obs_byte.size(); i++) begin
        checks++;
        if (obs_byte[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL break_value%0d got %h want %h", i, obs_byte[i], exp_q[i]);
        end
      end
    end
    clear_logs();
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] e;
    serial_data_in = 1'b0;
    repeat (N) tick();
    serial_data_in = 1'b1;
    repeat (3 * N + H) tick();
    rst = 1'b1;
    tick();
    checks++;
    if (rx_if.data_valid !== 1'b0 || rx_if.data_byte_op !== 8'h00) begin
      errors++;
      $display("FAIL rst_mid_outputs got valid=%b byte=%h want 0/00",
               rx_if.data_valid, rx_if.data_byte_op);
    end
    repeat (3) tick();
    rst = 1'b0;
    repeat (12 * N) tick();
    checks++;
    if (obs_byte.size() !== 0) begin
      errors++;
      $display("FAIL rst_mid_aborted got %0d strobes want 0", obs_byte.size());
    end
    exp_q.push_back(KEY_UP);
    send_frame(KEY_UP, 1'b1);
    repeat (2 * N) tick();
    checks++;
    if (obs_byte.size() !== 1) begin
      errors++;
      $display("FAIL rst_mid_count got %0d want 1", obs_byte.size());
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (obs_byte[0] !== e) begin
        errors++;
        $display("FAIL rst_mid_value got %h want %h", obs_byte[0], e);
      end
    end
    clear_logs();
  endtask

  task automatic test_strobe_rules();
    checks++;
    if (dv_double !== 0) begin
      errors++;
      $display("FAIL valid_consecutive got %0d want 0", dv_double);
    end
    checks++;
    if (byte_glitch !== 0) begin
      errors++;
      $display("FAIL byte_without_valid got %0d want 0", byte_glitch);
    end
  endtask

  initial begin
    test_reset();
    test_false_start();
    test_byte_up();
    test_back_to_back();
    test_bad_stop();
    test_break();
    test_reset_mid_frame();
    test_strobe_rules();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
